imem_loader: RTL

Boot-time writer for the instruction memory.
- Accepts a byte stream (valid/ready) from a host link such as a UART receiver.
- Assembles little-endian 32-bit instruction words and issues word-aligned write strobes into the instruction memory write port, starting at byte address 0.
- Holds the core in reset for the whole load, and releases it only after a load completes cleanly.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_packer.sv | 35 +++
 rtl/imem_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory boot loader.
// IMEM_LOADER_CKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int CKSUM_W        = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CKSUM_EN
        , S_CKSUM
`endif
    } state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word assembler shared by the length and data phases.
// word/word_valid are combinational so the FSM can act on the 4th byte's cycle.
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    // The three earlier bytes sit in shift_q; the 4th completes the word directly.
    assign word       = {byte_data, shift_q};
    assign word_valid = byte_en && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_en) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_data, shift_q[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: byte stream in, word writes out, core held in reset.
// Define IMEM_LOADER_CKSUM_EN to require a trailing 8-bit sum of all data bytes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N  = 2048,
    parameter int AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load_start,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte_data,
    output logic          o_byte_ready,
    output logic          o_we,
    output logic [AW-1:0] o_waddr,
    output logic [31:0]   o_wdata,
    output logic          o_cpu_hold,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output state_t        o_state
);

    localparam int IW = $clog2(N) + 1;

    // Byte stream handshake: a byte moves only in a cycle where
    // i_byte_valid and o_byte_ready are both high; valid may wait indefinitely.
    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] cnt_q;
    logic [IW-1:0] idx_next;
    logic          xfer;
    logic          pack_en;
    logic          pack_clear;
    logic          idle_like;
    logic [31:0]   word;
    logic          word_valid;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [CKSUM_W-1:0] sum_q;
`endif

    assign xfer       = i_byte_valid & o_byte_ready;
    assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign pack_en    = xfer && ((state_q == S_LEN) || (state_q == S_DATA));
    assign pack_clear = idle_like && i_load_start;
    assign idx_next   = idx_q + 1'b1;
    assign o_state    = state_q;

    byte_to_word_packer u_packer (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clear      (pack_clear),
        .byte_en    (pack_en),
        .byte_data  (i_byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            o_byte_ready <= 1'b0;
            o_we         <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_cpu_hold   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            o_we <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_load_start) begin
                        state_q      <= S_LEN;
                        idx_q        <= '0;
                        cnt_q        <= '0;
                        o_byte_ready <= 1'b1;
                        o_cpu_hold   <= 1'b1;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_err        <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
                        sum_q        <= '0;
`endif
                    end
                end

                S_LEN: begin
                    if (word_valid) begin
                        if (word > 32'(N)) begin
                            // Oversized image: keep the core held, it has nothing valid to run.
                            state_q      <= S_ERR;
                            o_byte_ready <= 1'b0;
                            o_busy       <= 1'b0;
                            o_err        <= 1'b1;
                        end else if (word == 32'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
                            state_q      <= S_CKSUM;
`else
                            state_q      <= S_DONE;
                            o_byte_ready <= 1'b0;
                            o_busy       <= 1'b0;
                            o_cpu_hold   <= 1'b0;
                            o_done       <= 1'b1;
`endif
                        end else begin
                            state_q <= S_DATA;
                            cnt_q   <= word[IW-1:0];
                        end
                    end
                end

                S_DATA: begin
`ifdef IMEM_LOADER_CKSUM_EN
                    if (xfer) begin
                        sum_q <= sum_q + i_byte_data;
                    end
`endif
                    if (word_valid) begin
                        state_q      <= S_WRITE;
                        o_byte_ready <= 1'b0;
                        o_we         <= 1'b1;
                        o_waddr      <= AW'({idx_q, 2'b00});
                        o_wdata      <= word;
                    end
                end

                S_WRITE: begin
                    idx_q <= idx_next;
                    if (idx_next == cnt_q) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        state_q      <= S_CKSUM;
                        o_byte_ready <= 1'b1;
`else
                        state_q      <= S_DONE;
                        o_busy       <= 1'b0;
                        o_cpu_hold   <= 1'b0;
                        o_done       <= 1'b1;
`endif
                    end else begin
                        state_q      <= S_DATA;
                        o_byte_ready <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (xfer) begin
                        o_byte_ready <= 1'b0;
                        o_busy       <= 1'b0;
                        if (i_byte_data == sum_q) begin
                            state_q    <= S_DONE;
                            o_cpu_hold <= 1'b0;
                            o_done     <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            o_err   <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state_q      <= S_IDLE;
                    o_byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
